sme_loader: RTL

- Host-side writer for the string-matching engine's shared string/pattern store.
- Accepts a job from the host as a byte stream with a valid/ready handshake: string bytes and pattern bytes, tagged by a select bit and closed by a last flag.
- Buffers the whole job internally, then replays it as one uninterrupted write burst (string, then pattern) on the store's byte-write interface.
- The store rewinds its write indices whenever write is low, so a host stall must never split a burst.

---
 rtl/sme_loader_if.sv | 21 ++
 rtl/sme_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sme_loader_if.sv
// Host byte stream into the loader and byte-write bus out to the string/pattern store.
interface sme_loader_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_sel;
   logic       in_last;
   logic [7:0] w_data;
   logic       write;
   logic       w_sel;

   modport master (
      output in_valid, in_data, in_sel, in_last,
      input  in_ready, w_data, write, w_sel
   );

   modport slave (
      input  in_valid, in_data, in_sel, in_last,
      output in_ready, w_data, write, w_sel
   );
endinterface

// File: rtl/sme_loader.sv
// Buffers one host job (string + pattern bytes) and replays it to the store as a
// single gap-free write burst, string first, then pattern.
module sme_loader #(
   parameter int MAX_STRING  = 32,
   parameter int MAX_PATTERN = 8,
   parameter bit PAD_ZERO    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   sme_loader_if.slave bus,
   output logic        busy,
   output logic        done,
   output logic [5:0]  str_len,
   output logic [3:0]  pat_len,
   output logic        overflow
);

   localparam int SAW = (MAX_STRING  > 1) ? $clog2(MAX_STRING)  : 1;
   localparam int PAW = (MAX_PATTERN > 1) ? $clog2(MAX_PATTERN) : 1;
   localparam logic [5:0] STR_MAX = 6'(MAX_STRING);
   localparam logic [3:0] PAT_MAX = 4'(MAX_PATTERN);

   typedef enum logic [1:0] {
      COLLECT  = 2'd0,
      SEND_STR = 2'd1,
      SEND_PAT = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t     state_r, nxt_state_s;
   logic [5:0] cnt_r, nxt_cnt_s;
   logic       job_open_r, nxt_job_open_s;

   logic [7:0] str_buf [MAX_STRING];
   logic [7:0] pat_buf [MAX_PATTERN];

   logic       accept_s, str_we_s, pat_we_s;
   logic [5:0] str_base_s, nxt_str_len_s, s_tot_s;
   logic [3:0] pat_base_s, nxt_pat_len_s, p_tot_s;
   logic       ovf_base_s, nxt_overflow_s;

   logic       nxt_in_ready_s, nxt_write_s, nxt_w_sel_s, nxt_busy_s, nxt_done_s;
   logic [7:0] nxt_w_data_s;

   assign accept_s = (state_r == COLLECT) && bus.in_valid && bus.in_ready;

   // Beat capture: lengths and overflow restart on the first beat of each job.
   always_comb begin
      str_base_s     = job_open_r ? str_len  : 6'd0;
      pat_base_s     = job_open_r ? pat_len  : 4'd0;
      ovf_base_s     = job_open_r ? overflow : 1'b0;
      nxt_str_len_s  = str_len;
      nxt_pat_len_s  = pat_len;
      nxt_overflow_s = overflow;
      nxt_job_open_s = job_open_r;
      str_we_s       = 1'b0;
      pat_we_s       = 1'b0;
      if (accept_s) begin
         nxt_str_len_s  = str_base_s;
         nxt_pat_len_s  = pat_base_s;
         nxt_overflow_s = ovf_base_s;
         nxt_job_open_s = !bus.in_last;
         if (!bus.in_sel) begin
            if (str_base_s == STR_MAX) begin
               nxt_overflow_s = 1'b1;
            end else begin
               str_we_s      = 1'b1;
               nxt_str_len_s = str_base_s + 6'd1;
            end
         end else begin
            if (pat_base_s == PAT_MAX) begin
               nxt_overflow_s = 1'b1;
            end else begin
               pat_we_s      = 1'b1;
               nxt_pat_len_s = pat_base_s + 4'd1;
            end
         end
      end else begin
         nxt_job_open_s = job_open_r;
      end
   end

   assign s_tot_s = PAD_ZERO ? STR_MAX : nxt_str_len_s;
   assign p_tot_s = PAD_ZERO ? PAT_MAX : nxt_pat_len_s;

   // Next-state and burst counter; counter restarts on every state change.
   always_comb begin
      nxt_state_s = state_r;
      case (state_r)
         COLLECT: begin
            if (accept_s && bus.in_last) begin
               if (s_tot_s != 6'd0)      nxt_state_s = SEND_STR;
               else if (p_tot_s != 4'd0) nxt_state_s = SEND_PAT;
               else                      nxt_state_s = DONE;
            end else begin
               nxt_state_s = COLLECT;
            end
         end
         SEND_STR: begin
            if (cnt_r == (s_tot_s - 6'd1)) begin
               if (p_tot_s != 4'd0) nxt_state_s = SEND_PAT;
               else                 nxt_state_s = DONE;
            end else begin
               nxt_state_s = SEND_STR;
            end
         end
         SEND_PAT: begin
            if (cnt_r == ({2'b00, p_tot_s} - 6'd1)) nxt_state_s = DONE;
            else                                    nxt_state_s = SEND_PAT;
         end
         DONE:    nxt_state_s = COLLECT;
         default: nxt_state_s = COLLECT;
      endcase
      if (nxt_state_s != state_r) begin
         nxt_cnt_s = 6'd0;
      end else if ((state_r == SEND_STR) || (state_r == SEND_PAT)) begin
         nxt_cnt_s = cnt_r + 6'd1;
      end else begin
         nxt_cnt_s = 6'd0;
      end
   end

   // Output decode from the upcoming state so every output can be registered
   // while the first burst byte still appears right after the last beat.
   always_comb begin
      nxt_in_ready_s = (nxt_state_s == COLLECT);
      nxt_write_s    = (nxt_state_s == SEND_STR) || (nxt_state_s == SEND_PAT);
      nxt_w_sel_s    = (nxt_state_s == SEND_PAT);
      nxt_busy_s     = (nxt_state_s != COLLECT);
      nxt_done_s     = (nxt_state_s == DONE);
      nxt_w_data_s   = 8'h00;
      case (nxt_state_s)
         SEND_STR: begin
            if (nxt_cnt_s < nxt_str_len_s) begin
               // A byte written on this same edge is not yet in the buffer.
               if (str_we_s && (str_base_s == nxt_cnt_s)) nxt_w_data_s = bus.in_data;
               else nxt_w_data_s = str_buf[nxt_cnt_s[SAW-1:0]];
            end else begin
               nxt_w_data_s = 8'h00;
            end
         end
         SEND_PAT: begin
            if (nxt_cnt_s < {2'b00, nxt_pat_len_s}) begin
               if (pat_we_s && ({2'b00, pat_base_s} == nxt_cnt_s)) nxt_w_data_s = bus.in_data;
               else nxt_w_data_s = pat_buf[nxt_cnt_s[PAW-1:0]];
            end else begin
               nxt_w_data_s = 8'h00;
            end
         end
         default: nxt_w_data_s = 8'h00;
      endcase
   end

   // State, burst counter and job-open flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= COLLECT;
         cnt_r      <= 6'd0;
         job_open_r <= 1'b0;
      end else begin
         state_r    <= nxt_state_s;
         cnt_r      <= nxt_cnt_s;
         job_open_r <= nxt_job_open_s;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.in_ready <= 1'b1;
         bus.write    <= 1'b0;
         bus.w_sel    <= 1'b0;
         bus.w_data   <= 8'h00;
         busy         <= 1'b0;
         done         <= 1'b0;
         str_len      <= 6'd0;
         pat_len      <= 4'd0;
         overflow     <= 1'b0;
      end else begin
         bus.in_ready <= nxt_in_ready_s;
         bus.write    <= nxt_write_s;
         bus.w_sel    <= nxt_w_sel_s;
         bus.w_data   <= nxt_w_data_s;
         busy         <= nxt_busy_s;
         done         <= nxt_done_s;
         str_len      <= nxt_str_len_s;
         pat_len      <= nxt_pat_len_s;
         overflow     <= nxt_overflow_s;
      end
   end

   // Job buffers; contents survive reset.
   always_ff @(posedge clk) begin
      if (str_we_s) str_buf[str_base_s[SAW-1:0]] <= bus.in_data;
      if (pat_we_s) pat_buf[pat_base_s[PAW-1:0]] <= bus.in_data;
   end

endmodule
